// File: rtl/pong_game_ctrl.sv
// Frame-rate game sequencer for the pong display path: ball and paddle positions,
// scores and the serve/play/done state machine. Positions advance once per frame_tick.
//
//   state   | meaning
//   QI      | idle, waiting for start
//   QGAME_1 | serve: ball held centred while serve_cnt counts frames
//   QGAME_2 | play: ball and paddles move every frame
//   QDONE   | a player reached WIN_SCORE, everything frozen
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 40,
  parameter int PAD1_X       = 20,
  parameter int PAD2_X       = 612,
  parameter int BALL_SZ      = 8,
  parameter int BALL_SPD     = 2,
  parameter int PAD_SPD      = 2,
  parameter int WIN_SCORE    = 10,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [8:0] pad1_y,
  output logic [8:0] pad2_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state
);

  localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  // All collision compares are done at 11 bits so sums never wrap.
  localparam logic [10:0] K_SCREEN_W  = 11'(SCREEN_W);
  localparam logic [10:0] K_BALL_YMAX = 11'(SCREEN_H - BALL_SZ);
  localparam logic [10:0] K_PAD_YMAX  = 11'(SCREEN_H - PAD_H);
  localparam logic [10:0] K_PAD_H     = 11'(PAD_H);
  localparam logic [10:0] K_BALL_SZ   = 11'(BALL_SZ);
  localparam logic [10:0] K_BALL_SPD  = 11'(BALL_SPD);
  localparam logic [10:0] K_PAD_SPD   = 11'(PAD_SPD);
  localparam logic [10:0] K_LEFT_HIT  = 11'(PAD1_X + PAD_W + BALL_SPD);
  localparam logic [10:0] K_PAD2_X    = 11'(PAD2_X);
  localparam logic [4:0]  K_WIN       = 5'(WIN_SCORE);

  localparam logic [9:0] BALL_X0     = 10'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [8:0] BALL_Y0     = 9'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [8:0] PAD_Y0      = 9'((SCREEN_H - PAD_H) / 2);
  localparam logic [9:0] BALL_XLSTOP = 10'(PAD1_X + PAD_W);
  localparam logic [9:0] BALL_XRSTOP = 10'(PAD2_X - BALL_SZ);
  localparam logic [8:0] BALL_YBOT   = 9'(SCREEN_H - BALL_SZ);
  localparam logic [9:0] X_STEP      = 10'(BALL_SPD);
  localparam logic [8:0] Y_STEP      = 9'(BALL_SPD);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [8:0]       ball_y_q, ball_y_d;
  logic [8:0]       pad1_y_q, pad1_y_d;
  logic [8:0]       pad2_y_q, pad2_y_d;
  logic [3:0]       p1_score_q, p1_score_d;
  logic [3:0]       p2_score_q, p2_score_d;
  logic             dx_q, dx_d;  // 1 = moving right
  logic             dy_q, dy_d;  // 1 = moving down
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;

  logic [10:0] bx_w, by_w, p1_w, p2_w;
  logic [8:0]  pad1_nxt, pad2_nxt;
  logic        tick_run, serve_done;
  logic        ov1, ov2, hit1, hit2, miss_l, miss_r, win;

  function automatic logic [8:0] pad_step(input logic [10:0] y, input logic up, input logic dn);
    logic [10:0] t;
    t = y;
    if (up && !dn) begin
      t = (y < K_PAD_SPD) ? 11'd0 : y - K_PAD_SPD;
    end else if (dn && !up) begin
      t = (y + K_PAD_SPD > K_PAD_YMAX) ? K_PAD_YMAX : y + K_PAD_SPD;
    end
    return t[8:0];
  endfunction

  assign bx_w = {1'b0, ball_x_q};
  assign by_w = {2'b00, ball_y_q};
  assign p1_w = {2'b00, pad1_y_q};
  assign p2_w = {2'b00, pad2_y_q};

  assign tick_run   = start && frame_tick;
  assign serve_done = (serve_cnt_q == SERVE_LAST);
  assign pad1_nxt   = pad_step(p1_w, p1_up, p1_dn);
  assign pad2_nxt   = pad_step(p2_w, p2_up, p2_dn);

  // Collision tests look at the paddles as they were before this tick.
  assign ov1    = (by_w + K_BALL_SZ > p1_w) && (by_w < p1_w + K_PAD_H);
  assign ov2    = (by_w + K_BALL_SZ > p2_w) && (by_w < p2_w + K_PAD_H);
  assign hit1   = !dx_q && (bx_w <= K_LEFT_HIT) && ov1;
  assign miss_l = !dx_q && !hit1 && (bx_w < K_BALL_SPD);
  assign hit2   = dx_q && (bx_w + K_BALL_SPD + K_BALL_SZ >= K_PAD2_X) && ov2;
  assign miss_r = dx_q && !hit2 && (bx_w + K_BALL_SPD + K_BALL_SZ > K_SCREEN_W);
  assign win    = (miss_r && (({1'b0, p1_score_q} + 5'd1) == K_WIN)) ||
                  (miss_l && (({1'b0, p2_score_q} + 5'd1) == K_WIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= QI;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      pad1_y_q    <= PAD_Y0;
      pad2_y_q    <= PAD_Y0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      pad1_y_q    <= pad1_y_d;
      pad2_y_q    <= pad2_y_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      QI: begin
        if (start) state_d = QGAME_1;
      end
      QGAME_1: begin
        if (!start) state_d = QI;
        else if (frame_tick && serve_done) state_d = QGAME_2;
      end
      QGAME_2: begin
        if (!start) state_d = QI;
        else if (frame_tick && (miss_l || miss_r)) state_d = win ? QDONE : QGAME_1;
      end
      QDONE: begin
        if (!start) state_d = QI;
      end
      default: state_d = QI;
    endcase
  end

  always_comb begin
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    pad1_y_d    = pad1_y_q;
    pad2_y_d    = pad2_y_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_cnt_d = serve_cnt_q;
    case (state_q)
      QI: begin
        if (start) begin
          p1_score_d  = '0;
          p2_score_d  = '0;
          ball_x_d    = BALL_X0;
          ball_y_d    = BALL_Y0;
          serve_cnt_d = '0;
        end
      end
      QGAME_1: begin
        if (tick_run) begin
          pad1_y_d    = pad1_nxt;
          pad2_y_d    = pad2_nxt;
          ball_x_d    = BALL_X0;
          ball_y_d    = BALL_Y0;
          serve_cnt_d = serve_done ? '0 : serve_cnt_q + CNT_W'(1);
        end
      end
      QGAME_2: begin
        if (tick_run) begin
          pad1_y_d = pad1_nxt;
          pad2_y_d = pad2_nxt;
          if (miss_l || miss_r) begin
            if (miss_r) p1_score_d = p1_score_q + 4'd1;
            else        p2_score_d = p2_score_q + 4'd1;
            // On a winning point the ball stays where it was.
            if (!win) begin
              ball_x_d = BALL_X0;
              ball_y_d = BALL_Y0;
              dx_d     = miss_l;
            end
          end else begin
            if (hit1) begin
              ball_x_d = BALL_XLSTOP;
              dx_d     = 1'b1;
            end else if (hit2) begin
              ball_x_d = BALL_XRSTOP;
              dx_d     = 1'b0;
            end else if (dx_q) begin
              ball_x_d = ball_x_q + X_STEP;
            end else begin
              ball_x_d = ball_x_q - X_STEP;
            end
            if (dy_q) begin
              if (by_w + K_BALL_SPD >= K_BALL_YMAX) begin
                ball_y_d = BALL_YBOT;
                dy_d     = 1'b0;
              end else begin
                ball_y_d = ball_y_q + Y_STEP;
              end
            end else begin
              if (by_w < K_BALL_SPD) begin
                ball_y_d = '0;
                dy_d     = 1'b1;
              end else begin
                ball_y_d = ball_y_q - Y_STEP;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ball_x   = ball_x_q;
    ball_y   = ball_y_q;
    pad1_y   = pad1_y_q;
    pad2_y   = pad2_y_q;
    p1_score = p1_score_q;
    p2_score = p2_score_q;
    state    = state_q;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: integer game model compared every cycle,
// deterministic serve/bounce/miss/paddle sequences, then randomized play through to a win.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] ball_x;
  logic [8:0] ball_y, pad1_y, pad2_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_tick(frame_tick),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad1_y(pad1_y), .pad2_y(pad2_y),
    .p1_score(p1_score), .p2_score(p2_score), .state(state)
  );

  // Game model in plain integers: velocity is a signed step, state uses the output code.
  int m_state, m_bx, m_by, m_vx, m_vy, m_p1y, m_p2y, m_s1, m_s2, m_serve;

  function automatic int move_pad(int y, logic up, logic dn);
    if (up && !dn) return (y - 2 < 0) ? 0 : y - 2;
    if (dn && !up) return (y + 2 > 440) ? 440 : y + 2;
    return y;
  endfunction

  task automatic model_reset();
    m_state = 0; m_bx = 316; m_by = 236; m_p1y = 220; m_p2y = 220;
    m_s1 = 0; m_s2 = 0; m_vx = 2; m_vy = 2; m_serve = 0;
  endtask

  task automatic model_step();
    int nx, ny, nvx, nvy, np1, np2, scorer;
    bit ov1, ov2;
    case (m_state)
      0: if (start) begin
        m_state = 1; m_s1 = 0; m_s2 = 0; m_bx = 316; m_by = 236; m_serve = 0;
      end
      1: if (!start) m_state = 0;
         else if (frame_tick) begin
           m_p1y = move_pad(m_p1y, p1_up, p1_dn);
           m_p2y = move_pad(m_p2y, p2_up, p2_dn);
           m_serve++;
           if (m_serve == 60) begin m_serve = 0; m_state = 2; end
         end
      2: if (!start) m_state = 0;
         else if (frame_tick) begin
           np1 = move_pad(m_p1y, p1_up, p1_dn);
           np2 = move_pad(m_p2y, p2_up, p2_dn);
           ov1 = (m_by + 8 > m_p1y) && (m_by < m_p1y + 40);
           ov2 = (m_by + 8 > m_p2y) && (m_by < m_p2y + 40);
           nx = m_bx + m_vx; ny = m_by + m_vy; nvx = m_vx; nvy = m_vy; scorer = 0;
           if (m_vx < 0) begin
             if (nx <= 28 && ov1) begin nx = 28; nvx = 2; end
             else if (nx < 0) scorer = 2;
           end else begin
             if (nx + 8 >= 612 && ov2) begin nx = 604; nvx = -2; end
             else if (nx + 8 > 640) scorer = 1;
           end
           if (ny >= 472) begin ny = 472; nvy = -2; end
           else if (ny < 0) begin ny = 0; nvy = 2; end
           m_p1y = np1; m_p2y = np2;
           if (scorer == 0) begin
             m_bx = nx; m_by = ny; m_vx = nvx; m_vy = nvy;
           end else begin
             if (scorer == 1) m_s1++; else m_s2++;
             if (m_s1 == 10 || m_s2 == 10) m_state = 3;
             else begin
               m_state = 1; m_bx = 316; m_by = 236;
               m_vx = (scorer == 1) ? -2 : 2;
             end
           end
         end
      3: if (!start) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("state",    int'(state),    m_state);
        check("ball_x",   int'(ball_x),   m_bx);
        check("ball_y",   int'(ball_y),   m_by);
        check("pad1_y",   int'(pad1_y),   m_p1y);
        check("pad2_y",   int'(pad2_y),   m_p2y);
        check("p1_score", int'(p1_score), m_s1);
        check("p2_score", int'(p2_score), m_s2);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk); #1 frame_tick = 1'b1;
      @(negedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_bx"},    int'(ball_x), 316);
    check({tag, "_by"},    int'(ball_y), 236);
    check({tag, "_pad1"},  int'(pad1_y), 220);
    check({tag, "_pad2"},  int'(pad2_y), 220);
    check({tag, "_s1"},    int'(p1_score), 0);
    check({tag, "_s2"},    int'(p2_score), 0);
  endtask

  initial begin
    int seen_done = 0;
    int done_cnt  = 0;
    bit was_done  = 1'b0;

    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(1);
    check_reset_vals("rst");

    // Serve, bounce off the bottom wall and a right-side miss with idle paddles.
    start = 1'b1;
    step(1);
    check("serve_enter", int'(state), 1);
    tick(59);
    check("serve_hold59", int'(state), 1);
    tick(1);
    check("serve_end", int'(state), 2);
    check("serve_end_bx", int'(ball_x), 316);
    tick(1);
    check("play1_bx", int'(ball_x), 318);
    check("play1_by", int'(ball_y), 238);
    tick(117);
    check("wall_hit_by", int'(ball_y), 472);
    tick(1);
    check("wall_away_by", int'(ball_y), 470);
    tick(40);
    check("miss_s1", int'(p1_score), 1);
    check("miss_state", int'(state), 1);
    check("miss_bx", int'(ball_x), 316);
    check("miss_by", int'(ball_y), 236);
    tick(61);
    check("reserve_state", int'(state), 2);
    check("reserve_bx", int'(ball_x), 314);
    check("reserve_by", int'(ball_y), 234);

    // Asynchronous reset in the middle of a clock period, mid-play.
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    step(2);
    start = 1'b0;
    reset_n = 1'b1;
    step(1);
    start = 1'b1;
    step(1);

    // Paddle saturation at both ends and the up+down hold.
    p1_up = 1'b1; p2_dn = 1'b1;
    tick(1);
    check("pad1_first", int'(pad1_y), 218);
    check("pad2_first", int'(pad2_y), 222);
    tick(109);
    check("pad1_top", int'(pad1_y), 0);
    check("pad2_bot", int'(pad2_y), 440);
    tick(5);
    check("pad1_top_hold", int'(pad1_y), 0);
    check("pad2_bot_hold", int'(pad2_y), 440);
    p1_dn = 1'b1;
    tick(3);
    check("pad1_both", int'(pad1_y), 0);
    p1_up = 1'b0;
    tick(1);
    check("pad1_down", int'(pad1_y), 2);
    p1_dn = 1'b0; p2_dn = 1'b0;

    start = 1'b0;
    step(2);
    start = 1'b1;

    // Randomized play; the right paddle is parked at the top early on so points come quickly.
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk); #1;
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) p1_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) p1_dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) p2_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) p2_dn = 1'($urandom_range(0, 1));
      if (cyc < 20000) begin p2_up = 1'b1; p2_dn = 1'b0; end
      if (m_state == 3) begin
        if (!was_done) begin
          seen_done++;
          done_cnt = 0;
          check("win_score", (p1_score > p2_score) ? int'(p1_score) : int'(p2_score), 10);
          check("win_state", int'(state), 3);
        end
        done_cnt++;
        if (done_cnt == 10) start = 1'b0;
      end else if (!start) begin
        start = 1'b1;
      end else if (cyc >= 20000 && $urandom_range(0, 19999) == 0) begin
        start = 1'b0;
      end
      was_done = (m_state == 3);
      if (cyc == 30000) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    check("done_reached", int'(seen_done > 0), 1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
